instr_fetch: RTL

- Fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the word-aligned byte address to the memory. The memory returns the instruction combinationally in the same cycle.
- Buffers each {pc, instr} pair in a small FIFO and presents it to decode over a valid/ready handshake.
- Takes redirects (branch/jump/trap targets) from execute and flushes wrong-path instructions.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/instr_fetch.sv | 120 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants for the instruction fetch slice.
// Optional feature macro honoured by users of this package: INSTR_FETCH_MISALIGN_TRAP_EN.
package riscv_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      TRAP = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // True when a byte address is not on a 4-byte instruction boundary.
   function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO of {pc, instr} entries between fetch and decode.
// clear empties the FIFO and wins over push/pop in the same cycle.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   input  logic         clear,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem[rd_ptr];

   // Entry storage; contents beyond count are don't-care, so no reset needed.
   always_ff @(posedge clk) begin
      if (!reset && !clear && do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads the instruction memory combinationally and
// queues {pc, instr} toward decode. Redirects flush wrong-path entries.
// Optional macro INSTR_FETCH_MISALIGN_TRAP_EN: misaligned redirects enter TRAP
// instead of being silently aligned, and fetch_misaligned is exported.
//
// Decode handshake: an entry transfers on a rising edge where out_valid=1 and
// out_ready=1 (and no redirect); while out_valid=1 and out_ready=0 the head
// out_pc/out_instr hold steady. out_valid never depends on out_ready.
module instr_fetch
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          DEPTH        = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            fetch_en,
   output logic [XLEN-1:0] imem_pc,
   input  logic [XLEN-1:0] imem_instr,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_instr,
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
   output logic            fetch_misaligned,
`endif
   output logic [1:0]      dbg_state
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_RUN  = RUN;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
   localparam logic [1:0] ST_TRAP = TRAP;
`endif

   logic [1:0]      state;
   logic [1:0]      state_nxt;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] redirect_target;
   logic            fifo_full;
   logic            fifo_empty;
   logic            pop;
   logic            fetch;
   fetch_entry_t    push_entry;
   fetch_entry_t    head;

   assign imem_pc   = pc;
   assign dbg_state = state;
   assign out_valid = !fifo_empty;
   assign out_pc    = fifo_empty ? '0 : head.pc;
   assign out_instr = fifo_empty ? '0 : head.instr;

   // A redirect cycle neither pops nor pushes; the flush discards everything.
   assign pop   = out_valid && out_ready && !redirect_valid;
   assign fetch = (state == ST_RUN) && !redirect_valid && (!fifo_full || pop);

   assign push_entry.pc    = pc;
   assign push_entry.instr = imem_instr;

`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
   assign redirect_target  = redirect_pc;
   assign fetch_misaligned = (state == ST_TRAP);
`else
   assign redirect_target  = is_misaligned(redirect_pc) ? {redirect_pc[XLEN-1:2], 2'b00}
                                                        : redirect_pc;
`endif

   // Next FSM state: fetch_en gates IDLE/RUN; redirects only matter for TRAP.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (fetch_en)  state_nxt = ST_RUN;
         ST_RUN:  if (!fetch_en) state_nxt = ST_IDLE;
         default: state_nxt = state;
      endcase
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
      if (redirect_valid) begin
         if (is_misaligned(redirect_pc)) begin
            state_nxt = ST_TRAP;
         end else if (state == ST_TRAP) begin
            state_nxt = fetch_en ? ST_RUN : ST_IDLE;
         end
      end
`endif
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Program counter: reset, redirect target, or sequential advance on fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= RESET_VECTOR;
      end else if (redirect_valid) begin
         pc <= redirect_target;
      end else if (fetch) begin
         pc <= pc + XLEN'(INSTR_BYTES);
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fetch),
      .push_data (push_entry),
      .pop       (pop),
      .clear     (redirect_valid),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (head)
   );

endmodule
